// File: rtl/mult_div_unit.sv
// mult_div_unit: radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO (ports clk_i, rst_i, start_i, op_i, a_i, b_i -> busy_o, done_o, hi_o, lo_o)
module mult_div_unit #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);
  localparam int CW = $clog2(Width);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [Width-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, opnd_q, opnd_d, quo_q, quo_d, rem_q, rem_d;
  logic div_q, div_d, bz_q, bz_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic sgn, a_neg, b_neg, ge, accept;
  logic [Width-1:0] a_mag, b_mag, rem_n, quo_n;
  logic [Width:0] sum, shifted;
  logic [2*Width-1:0] prod;
  assign sgn     = (op_i == 3'd0) || (op_i == 3'd2);
  assign a_neg   = sgn & a_i[Width-1];
  assign b_neg   = sgn & b_i[Width-1];
  assign a_mag   = a_neg ? -a_i : a_i;
  assign b_mag   = b_neg ? -b_i : b_i;
  assign accept  = start_i && (state_q != CALC);
  assign sum     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
  assign shifted = {rem_q, quo_q[Width-1]};
  assign ge      = shifted >= {1'b0, opnd_q};
  assign rem_n   = div_q ? (ge ? shifted[Width-1:0] - opnd_q : shifted[Width-1:0]) : sum[Width:1];
  assign quo_n   = div_q ? {quo_q[Width-2:0], ge} : {sum[0], quo_q[Width-1:1]};
  assign prod    = qneg_q ? -{rem_n, quo_n} : {rem_n, quo_n};
  always_comb begin
    state_d = state_q == DONE ? IDLE : state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    opnd_d  = opnd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    bz_d    = bz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (accept) begin
      state_d = op_i[2] ? IDLE : CALC;
      hi_d    = op_i == 3'd4 ? a_i : hi_q;
      lo_d    = op_i == 3'd5 ? a_i : lo_q;
      if (!op_i[2]) begin
        cnt_d  = '0;
        div_d  = op_i[1];
        a_d    = a_i;
        bz_d   = b_i == '0;
        opnd_d = op_i[1] ? b_mag : a_mag;
        quo_d  = op_i[1] ? a_mag : b_mag;
        rem_d  = '0;
        qneg_d = a_neg ^ b_neg;
        rneg_d = op_i[1] & a_neg;
      end
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 1'b1;
      rem_d = rem_n;
      quo_d = quo_n;
      if (cnt_q == CW'(Width - 1)) begin
        state_d = DONE;
        hi_d    = !div_q ? prod[2*Width-1:Width] : bz_q ? a_q : rneg_q ? -rem_n : rem_n;
        lo_d    = !div_q ? prod[Width-1:0] : bz_q ? '1 : qneg_q ? -quo_n : quo_n;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      opnd_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= 1'b0;
      bz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      opnd_q  <= opnd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      bz_q    <= bz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end
  assign busy_o = state_q == CALC;
  assign done_o = state_q == DONE;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;
  logic clk_i = 0, rst_i = 1, start_i = 0;
  logic [2:0] op_i = 0;
  logic [31:0] a_i = 0, b_i = 0;
  logic busy_o, done_o;
  logic [31:0] hi_o, lo_o;
  int checks = 0, errors = 0;
  logic [63:0] exp_q[$];
  mult_div_unit #(.Width(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done hi=%h lo=%h", hi_o, lo_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi_o, lo_o} !== e) begin
          errors++;
          $display("FAIL result got hi=%h lo=%h expected hi=%h lo=%h", hi_o, lo_o, e[63:32], e[31:0]);
        end
      end
    end
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1; op_i = op; a_i = a; b_i = b;
    @(negedge clk_i);
    start_i = 0; a_i = 32'hDEAD_BEEF; b_i = 32'h0BAD_F00D;
  endtask
  task automatic issue_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el);
    exp_q.push_back({eh, el});
    issue(op, a, b);
  endtask
  task automatic wait_done(input string name);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy_o) n++;
      if (done_o) begin
        seen = 1;
        break;
      end
      @(negedge clk_i);
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_busy_cycles"}, n, 32);
  endtask
  initial begin
    int d;
    repeat (2) @(negedge clk_i);
    check("reset_busy", 32'(busy_o), 0);
    check("reset_done", 32'(done_o), 0);
    check("reset_hi", hi_o, 0);
    check("reset_lo", lo_o, 0);
    rst_i = 0;
    issue_exp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done("multu");
    @(negedge clk_i);
    check("multu_done_pulse", 32'(done_o), 0);
    issue_exp(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    wait_done("mult_neg");
    issue_exp(3'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'h0, 32'h18);
    wait_done("mult_negneg");
    issue_exp(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done("div_neg");
    issue_exp(3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    wait_done("div_negdivisor");
    issue_exp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    wait_done("div_ovf");
    issue_exp(3'd1, 32'd6, 32'd7, 32'd0, 32'd42);
    wait_done("b2b_first");
    issue_exp(3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_done("b2b_second");
    issue_exp(3'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    wait_done("divu_zero");
    @(negedge clk_i);
    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    check("nop_busy", 32'(busy_o), 0);
    check("nop_hi", hi_o, 32'h1234_5678);
    check("nop_lo", lo_o, 32'hFFFF_FFFF);
    issue(3'd4, 32'h0000_CAFE, 32'h0);
    check("mthi_hi", hi_o, 32'h0000_CAFE);
    check("mthi_busy", 32'(busy_o), 0);
    issue(3'd3, 32'd1000, 32'd3);
    repeat (3) @(negedge clk_i);
    issue(3'd4, 32'h0000_AAAA, 32'h0);
    check("busy_ignore_hi", hi_o, 32'h0000_CAFE);
    check("busy_ignore_busy", 32'(busy_o), 1);
    repeat (4) @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_done", 32'(done_o), 0);
    check("midrst_hi", hi_o, 0);
    check("midrst_lo", lo_o, 0);
    d = 0;
    repeat (40) begin
      if (done_o || busy_o) d++;
      @(negedge clk_i);
    end
    check("midrst_no_activity", d, 0);
    issue(3'd5, 32'h0000_0055, 32'h0);
    check("mtlo_lo", lo_o, 32'h0000_0055);
    check("mtlo_busy", 32'(busy_o), 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
